muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
- Executes MULT, MULTU, DIV, DIVU at one bit per cycle, and services MTHI/MTLO writes.
- Raises busy so the hazard logic can stall MFHI/MFLO and further mul/div ops.
- Sits beside the EX-stage ALU and is driven by the decoded instruction in EX.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit with HI/LO result registers for the MIPS
//   EX stage. MULT/MULTU use shift-and-add and DIV/DIVU use restoring division,
//   both at one bit per cycle. Signed operations run on operand magnitudes and
//   the result signs are corrected in a final FIX cycle. MTHI/MTLO writes go
//   straight into HI/LO while the unit is idle.
//
// Configuration macro:
//   MULDIV_EARLY_TERM_EN - when defined, a multiply leaves RUN as soon as the
//                          remaining multiplier is zero. Divides always take
//                          WIDTH iterations.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, op, a, b   operation request (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   flush             abort any in-flight operation without touching HI/LO
//   hi_we, lo_we      MTHI/MTLO write enables, wdata is the write data
//   busy              operation in flight
//   done              one-cycle pulse after HI/LO are written by an operation
//   div_by_zero       pulses with done when a divide had b == 0
//   hi, lo            HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t               r_state;
  logic                 r_is_div;
  logic                 r_neg_q;    // product sign (mult) or quotient sign (div)
  logic                 r_neg_r;    // remainder sign follows the dividend
  logic                 r_b_zero;
  logic                 r_done;
  logic                 r_dbz;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;      // product accumulator
  logic [2*WIDTH-1:0]   r_mcand;    // multiplicand, shifts left
  logic [WIDTH-1:0]     r_mplier;   // multiplier (shifts right) or divisor (static)
  logic [WIDTH-1:0]     r_quo;      // dividend shifts out the top, quotient in the bottom
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_ok;
  logic                 w_last;
  logic                 w_start_fix;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // op[0] selects the signed variants
  assign w_a_neg = op[0] & a[WIDTH-1];
  assign w_b_neg = op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Restoring step: the trial difference is non-negative when its MSB is clear.
  // A zero divisor always succeeds, giving an all-ones quotient and rem = |a|,
  // which the sign fix turns into the required divide-by-zero results.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_mplier};
  assign w_ok     = ~w_diff[WIDTH];

`ifdef MULDIV_EARLY_TERM_EN
  // Leave RUN on the iteration that shifts out the last set multiplier bit;
  // a zero multiplier skips RUN entirely.
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1)) ||
                       (~r_is_div && (r_mplier[WIDTH-1:1] == '0));
  assign w_start_fix = ~op[1] && (b == '0);
`else
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_start_fix = 1'b0;
`endif

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (flush) begin
        // Abort wins over everything, including a start in the same cycle
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_is_div <= op[1];
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_b_zero <= (b == '0);
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
              r_mplier <= w_b_mag;
              r_quo    <= w_a_mag;
              r_rem    <= '0;
              r_state  <= w_start_fix ? S_FIX : S_RUN;
            end else begin
              if (hi_we) r_hi <= wdata;
              if (lo_we) r_lo <= wdata;
            end
          end
          S_RUN: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
              r_rem <= w_ok ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], w_ok};
            end else begin
              r_acc    <= w_acc_sum;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
            end
            if (w_last) r_state <= S_FIX;
          end
          S_FIX: begin
            if (r_is_div) begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
            r_done  <= 1'b1;
            r_dbz   <= r_is_div & r_b_zero;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected architectural HI/LO, maintained by the bench
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected busy length: WIDTH iterations plus FIX, or n+1 for early-exit multiplies
  function automatic int exp_busy(input logic [1:0] o, input logic [31:0] y);
    int n;
    logic [31:0] m;
    n = 32;
    m = y;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      if (o[0] && y[31]) m = -y;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`endif
    return n + 1;
  endfunction

  // Reference result {dbz, hi, lo} from plain arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [31:0] q, r;
    logic        z;
    int          sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    z  = 1'b0;
    p  = 64'h0;
    q  = 32'h0;
    r  = 32'h0;
    case (o)
      2'd0: p = {32'h0, x} * {32'h0, y};
      2'd1: p = 64'(longint'(sx) * longint'(sy));
      2'd2: begin
        if (y == 32'h0) begin z = 1'b1; q = 32'hFFFFFFFF; r = x; end
        else begin q = x / y; r = x % y; end
      end
      default: begin
        if (y == 32'h0) begin
          z = 1'b1; r = x;
          q = x[31] ? 32'h1 : 32'hFFFFFFFF;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          q = x; r = 32'h0;
        end else begin
          q = 32'(sx / sy); r = 32'(sx % sy);
        end
      end
    endcase
    if (o[1]) p = {r, q};
    return {z, p};
  endfunction

  // Drive a start at the current negedge and let it be sampled by one edge
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Wait out an issued operation, optionally hammering start/hi_we/lo_we while busy
  task automatic complete(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input bit noise, input int cyc0);
    int cyc;
    cyc = cyc0;
    forever begin
      @(negedge clk);
      if (!busy || cyc >= 200) break;
      cyc++;
      if (noise) begin
        check({tag, " hi stable while busy"}, 64'(hi), 64'(model_hi));
        check({tag, " lo stable while busy"}, 64'(lo), 64'(model_lo));
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        op = 2'($urandom); a = $urandom; b = $urandom; wdata = $urandom;
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({tag, " busy cycles"}, 64'(cyc), 64'(exp_busy(o, y)));
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
    model_hi = ehi;
    model_lo = elo;
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b busy=%0d",
             tag, o, x, y, hi, lo, div_by_zero, cyc);
  endtask

  task automatic run_model(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input bit noise);
    logic [64:0] m;
    m = model(o, x, y);
    issue(o, x, y);
    complete(tag, o, x, y, m[63:32], m[31:0], m[64], noise, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [64:0] m;
    int          cnt;

    vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'd2, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001, 1'b1};
    vecs[6]  = '{2'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'd0, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[8]  = '{2'd0, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[9]  = '{2'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[11] = '{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

    rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset dbz", 64'(div_by_zero), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back to back: each start lands in the done cycle
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      complete($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].dbz, 1'b0, 0);
    end

    // MTHI / MTLO while idle
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", 64'(hi), 64'(32'h00001234));
    check("mthi lo untouched", 64'(lo), 64'(model_lo));
    model_hi = 32'h00001234;
    lo_we = 1'b1; wdata = 32'h0000ABCD;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", 64'(lo), 64'(32'h0000ABCD));
    check("mtlo hi untouched", 64'(hi), 64'(model_hi));
    model_lo = 32'h0000ABCD;
    $display("mthi/mtlo hi=%h lo=%h", hi, lo);

    // start has priority over hi_we/lo_we in the same cycle
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    issue(2'd0, 32'd2, 32'd3);
    @(negedge clk);
    check("start-prio busy", 64'(busy), 64'(1));
    check("start-prio hi", 64'(hi), 64'(model_hi));
    check("start-prio lo", 64'(lo), 64'(model_lo));
    complete("start-prio", 2'd0, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 1'b0, 1);

    // Writes and extra starts during busy are ignored
    run_model("noisy-div", 2'd3, 32'hFFFF0001, 32'h00000123, 1'b1);
    run_model("noisy-mul", 2'd1, 32'h00012345, 32'hFFFFFF00, 1'b1);

    // Flush in the 10th busy cycle, with a competing start
    issue(2'd0, 32'd3, 32'd5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("flush pre busy count", 64'(cnt), 64'(10));
    flush = 1'b1; start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
    @(negedge clk);
    check("flush busy", 64'(busy), 64'(0));
    check("flush done", 64'(done), 64'(0));
    check("flush hi", 64'(hi), 64'(model_hi));
    check("flush lo", 64'(lo), 64'(model_lo));
    // flush and start together while idle: nothing starts
    @(negedge clk);
    check("flush+start idle busy", 64'(busy), 64'(0));
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post-flush busy", 64'(busy), 64'(0));
    check("post-flush done", 64'(done), 64'(0));
    check("post-flush dbz", 64'(div_by_zero), 64'(0));
    check("post-flush hi", 64'(hi), 64'(model_hi));
    check("post-flush lo", 64'(lo), 64'(model_lo));
    $display("flush hi=%h lo=%h busy=%b", hi, lo, busy);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 255));
        2: rb = -32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_model($sformatf("rand%0d", i), ro, ra, rb, i[0]);
    end

    // Check the done pulse is exactly one cycle
    @(negedge clk);
    check("done one-cycle", 64'(done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
